// File: rtl/spi_pkg.sv
// Shared definitions for the SPI mode-3 slave: state encoding, frame size
// and the idle levels of the SPI lines.
package spi_pkg;

  localparam int SPI_BITS = 8;
  localparam int CNT_W    = $clog2(SPI_BITS);

  // Idle levels: sclk idles high in mode 3, cs_n is inactive high, and
  // miso is parked high whenever the slave is not shifting.
  localparam logic SCLK_IDLE = 1'b1;
  localparam logic CS_N_IDLE = 1'b1;
  localparam logic MOSI_IDLE = 1'b1;
  localparam logic MISO_IDLE = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer bringing one asynchronous SPI line into clk.
// The reset value lets each line come out of reset at its idle level so
// no false edge is seen immediately after reset.
module spi_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_first
        // First stage samples the raw asynchronous input.
        always_ff @(posedge clk) begin
          if (rst) chain_reg[gi] <= RST_VAL;
          else     chain_reg[gi] <= d;
        end
      end else begin : g_rest
        // Later stages give the first flop time to resolve metastability.
        always_ff @(posedge clk) begin
          if (rst) chain_reg[gi] <= RST_VAL;
          else     chain_reg[gi] <= chain_reg[gi-1];
        end
      end
    end
  endgenerate

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/spi_slave_xfer.sv
// SPI mode-3 (CPOL=1, CPHA=1) slave, MSB first, 8-bit frames, fully
// oversampled by clk. Back-to-back bytes within one cs_n assertion are
// supported; tx_data is captured at frame start and at every byte end.
// Optional feature: define SPI_SLAVE_OVERRUN_EN to enable the sticky
// rx_overrun flag; otherwise rx_overrun is tied low.
module spi_slave_xfer
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sclk,
  input  logic                cs_n,
  input  logic                mosi,
  output logic                miso,
  input  logic [SPI_BITS-1:0] tx_data,
  output logic                tx_taken,
  output logic [SPI_BITS-1:0] rx_data,
  output logic                rx_valid,
  input  logic                rx_ack,
  output logic                busy,
  output logic                rx_overrun
);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_prev_reg, cs_n_prev_reg;
  logic sclk_rise, sclk_fall, cs_fall, cs_rise;

  state_t state_reg, state_next;
  logic   start, shift_out, shift_in, byte_done;

  logic [SPI_BITS-1:0] tx_shift_reg;
  logic [SPI_BITS-1:0] rx_shift_reg;
  logic [CNT_W-1:0]    bit_cnt_reg;
  logic                miso_reg;
  logic [SPI_BITS-1:0] rx_data_reg;
  logic                rx_valid_reg;
  logic                tx_taken_reg;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(SCLK_IDLE)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(sclk), .q(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(CS_N_IDLE)) u_sync_cs_n (
    .clk(clk), .rst(rst), .d(cs_n), .q(cs_n_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(MOSI_IDLE)) u_sync_mosi (
    .clk(clk), .rst(rst), .d(mosi), .q(mosi_s)
  );

  // Delayed copies of the synchronized lines for edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_prev_reg <= SCLK_IDLE;
      cs_n_prev_reg <= CS_N_IDLE;
    end else begin
      sclk_prev_reg <= sclk_s;
      cs_n_prev_reg <= cs_n_s;
    end
  end

  assign sclk_rise = ~sclk_prev_reg &  sclk_s;
  assign sclk_fall =  sclk_prev_reg & ~sclk_s;
  assign cs_fall   =  cs_n_prev_reg & ~cs_n_s;
  assign cs_rise   = ~cs_n_prev_reg &  cs_n_s;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= ST_IDLE;
    else     state_reg <= state_next;
  end

  // Next state and per-cycle actions; cs_n deassertion overrides any sclk edge.
  always_comb begin
    state_next = state_reg;
    start      = 1'b0;
    shift_out  = 1'b0;
    shift_in   = 1'b0;
    byte_done  = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (cs_fall) begin
          state_next = ST_SHIFT;
          start      = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_next = ST_IDLE;
        end else begin
          shift_out = sclk_fall;
          shift_in  = sclk_rise;
          byte_done = sclk_rise && (bit_cnt_reg == CNT_W'(SPI_BITS - 1));
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Shift registers, bit counter, miso driver and received-byte capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_shift_reg <= '1;
      rx_shift_reg <= '0;
      bit_cnt_reg  <= '0;
      miso_reg     <= MISO_IDLE;
      rx_data_reg  <= '0;
      tx_taken_reg <= 1'b0;
    end else begin
      tx_taken_reg <= 1'b0;
      if (cs_rise) begin
        // Frame aborted or finished: drop any partial byte, park miso.
        miso_reg    <= MISO_IDLE;
        bit_cnt_reg <= '0;
      end else if (start) begin
        tx_shift_reg <= tx_data;
        bit_cnt_reg  <= '0;
        tx_taken_reg <= 1'b1;
        miso_reg     <= MISO_IDLE;
      end else begin
        if (shift_out) begin
          miso_reg     <= tx_shift_reg[SPI_BITS-1];
          tx_shift_reg <= {tx_shift_reg[SPI_BITS-2:0], 1'b1};
        end
        if (shift_in) begin
          rx_shift_reg <= {rx_shift_reg[SPI_BITS-2:0], mosi_s};
          if (byte_done) begin
            bit_cnt_reg  <= '0;
            rx_data_reg  <= {rx_shift_reg[SPI_BITS-2:0], mosi_s};
            tx_shift_reg <= tx_data;
            tx_taken_reg <= 1'b1;
          end else begin
            bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
          end
        end
      end
    end
  end

  // rx_valid: a completing byte beats a simultaneous acknowledge.
  always_ff @(posedge clk) begin
    if (rst)            rx_valid_reg <= 1'b0;
    else if (byte_done) rx_valid_reg <= 1'b1;
    else if (rx_ack)    rx_valid_reg <= 1'b0;
  end

`ifdef SPI_SLAVE_OVERRUN_EN
  logic rx_overrun_reg;

  // Sticky overrun: a byte landed on top of an unacknowledged one.
  always_ff @(posedge clk) begin
    if (rst)                                    rx_overrun_reg <= 1'b0;
    else if (rx_ack)                            rx_overrun_reg <= 1'b0;
    else if (byte_done && rx_valid_reg)         rx_overrun_reg <= 1'b1;
  end

  assign rx_overrun = rx_overrun_reg;
`else
  assign rx_overrun = 1'b0;
`endif

  assign miso     = miso_reg;
  assign tx_taken = tx_taken_reg;
  assign rx_data  = rx_data_reg;
  assign rx_valid = rx_valid_reg;
  assign busy     = ~cs_n_s;

endmodule

// File: tb/tb_spi_slave_xfer.sv
// Self-checking bench for spi_slave_xfer: directed scenarios followed by a
// randomized multi-byte frame, checked against a transaction-level model.
module tb_spi_slave_xfer;

  localparam int SYNC = 2;
  localparam int HALF = 12;  // sclk half period in clk cycles (~2 MHz)
`ifdef SPI_SLAVE_OVERRUN_EN
  localparam bit OVR_EN = 1'b1;
`else
  localparam bit OVR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, sclk, cs_n, mosi, rx_ack;
  logic [7:0] tx_data;
  logic       miso, tx_taken, rx_valid, busy, rx_overrun;
  logic [7:0] rx_data;

  int compared   = 0;
  int mismatched = 0;
  int taken_cnt  = 0;

  // Transaction-level model of the receive side.
  logic [7:0] mdl_rx;
  bit         mdl_valid;
  bit         mdl_ovr;

  spi_slave_xfer #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .miso(miso), .tx_data(tx_data), .tx_taken(tx_taken),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
    .busy(busy), .rx_overrun(rx_overrun)
  );

  always #10 clk = ~clk;

  always @(posedge clk) taken_cnt <= taken_cnt + int'(tx_taken);

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_done(input logic [7:0] b, input bit ack_same);
    if (ack_same)       mdl_ovr = 1'b0;
    else if (mdl_valid) mdl_ovr = OVR_EN;
    mdl_valid = 1'b1;
    mdl_rx    = b;
  endtask

  task automatic model_check(input string tag);
    chk({tag, "_rx_data"},  rx_data,    mdl_rx);
    chk({tag, "_rx_valid"}, rx_valid,   mdl_valid);
    chk({tag, "_overrun"},  rx_overrun, mdl_ovr);
  endtask

  task automatic ack_pulse();
    @(negedge clk) rx_ack = 1'b1;
    @(negedge clk) rx_ack = 1'b0;
    mdl_valid = 1'b0;
    mdl_ovr   = 1'b0;
  endtask

  // Open a frame and wait (bounded) for the start-of-frame tx_taken.
  task automatic frame_start(input string tag);
    int  base;
    bit  ok;
    base = taken_cnt;
    ok   = 1'b0;
    @(negedge clk) cs_n = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (taken_cnt > base) ok = 1'b1;
    end
    chk({tag, "_start_taken"}, ok, 1'b1);
    repeat (4) @(negedge clk);
  endtask

  task automatic frame_end();
    @(negedge clk) cs_n = 1'b1;
    repeat (SYNC + 4) @(negedge clk);
  endtask

  // Master side of one (possibly partial) byte; optional rx_ack timed to
  // land in the very clk cycle the slave completes the byte.
  task automatic xfer(input logic [7:0] mo, input int nbits, input bit ack_end,
                      output logic [7:0] mi);
    mi = '0;
    for (int i = 7; i >= 8 - nbits; i--) begin
      @(negedge clk);
      sclk = 1'b0;
      mosi = mo[i];
      repeat (HALF) @(negedge clk);
      mi[i] = miso;
      sclk  = 1'b1;
      if (ack_end && i == 0) begin
        repeat (SYNC) @(negedge clk);
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        repeat (HALF - SYNC - 1) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
    end
    $display("xfer bits=%0d mosi=%02h miso=%02h", nbits, mo, mi);
  endtask

  initial begin
    logic [7:0] mi, mi2, t, m;
    logic [7:0] txq [0:12];
    int base;

    rst = 1'b1; sclk = 1'b1; cs_n = 1'b1; mosi = 1'b1; rx_ack = 1'b0; tx_data = '0;
    mdl_rx = '0; mdl_valid = 1'b0; mdl_ovr = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_miso", miso, 1'b1);
    chk("rst_tx_taken", tx_taken, 1'b0);
    chk("rst_busy", busy, 1'b0);
    model_check("rst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single byte: A5 back to master, 3C received.
    tx_data = 8'hA5;
    base = taken_cnt;
    frame_start("t1");
    chk("t1_one_taken_at_start", taken_cnt - base, 1);
    chk("t1_busy", busy, 1'b1);
    xfer(8'h3C, 8, 1'b0, mi);
    model_done(8'h3C, 1'b0);
    chk("t1_master_rx", mi, 8'hA5);
    chk("t1_taken_after_byte", taken_cnt - base, 2);
    model_check("t1");
    frame_end();
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_miso_end", miso, 1'b1);
    ack_pulse();
    model_check("t1_ack");

    // Two bytes in one frame, new tx byte presented after first tx_taken;
    // no acknowledge between them.
    tx_data = 8'hA5;
    base = taken_cnt;
    frame_start("t2");
    tx_data = 8'h0F;
    xfer(8'h5A, 8, 1'b0, mi);
    model_done(8'h5A, 1'b0);
    chk("t2_taken_after_first", taken_cnt - base, 2);
    xfer(8'hC3, 8, 1'b0, mi2);
    model_done(8'hC3, 1'b0);
    chk("t2_master_rx0", mi, 8'hA5);
    chk("t2_master_rx1", mi2, 8'h0F);
    chk("t2_taken_total", taken_cnt - base, 3);
    model_check("t2");
    frame_end();
    ack_pulse();
    model_check("t2_ack");

    // Partial byte aborted by cs_n after 5 bits.
    tx_data = 8'h00;
    frame_start("t3");
    xfer(8'hFF, 5, 1'b0, mi);
    chk("t3_miso_driven", miso, 1'b0);
    @(negedge clk) cs_n = 1'b1;
    repeat (SYNC + 2) @(negedge clk);
    chk("t3_miso_idle", miso, 1'b1);
    chk("t3_busy", busy, 1'b0);
    model_check("t3");

    // Reset in the middle of a byte, then a clean transfer of 81.
    tx_data = 8'h66;
    frame_start("t4");
    xfer(8'hF0, 4, 1'b0, mi);
    @(negedge clk) begin rst = 1'b1; cs_n = 1'b1; sclk = 1'b1; end
    @(negedge clk);
    mdl_rx = '0; mdl_valid = 1'b0; mdl_ovr = 1'b0;
    chk("t4_rst_miso", miso, 1'b1);
    chk("t4_rst_tx_taken", tx_taken, 1'b0);
    chk("t4_rst_busy", busy, 1'b0);
    model_check("t4_rst");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    t = 8'($urandom);
    tx_data = t;
    frame_start("t4b");
    tx_data = 8'h3E;
    xfer(8'h81, 8, 1'b0, mi);
    model_done(8'h81, 1'b0);
    chk("t4_master_rx", mi, t);
    model_check("t4b");

    // Acknowledge coincident with the next byte completing.
    m = 8'($urandom);
    xfer(m, 8, 1'b1, mi);
    model_done(m, 1'b1);
    chk("t5_master_rx", mi, 8'h3E);
    model_check("t5");
    @(negedge clk);
    model_check("t5_hold");
    frame_end();
    ack_pulse();

    // Randomized back-to-back frame.
    for (int k = 0; k < 13; k++) txq[k] = 8'($urandom);
    tx_data = txq[0];
    frame_start("rnd");
    for (int k = 0; k < 12; k++) begin
      bit ack_same;
      tx_data  = txq[k+1];
      m        = 8'($urandom);
      ack_same = ($urandom_range(0, 3) == 0);
      xfer(m, 8, ack_same, mi);
      model_done(m, ack_same);
      chk("rnd_master_rx", mi, txq[k]);
      model_check("rnd");
      if ($urandom_range(0, 1) == 1) begin
        ack_pulse();
        model_check("rnd_ack");
      end
    end
    frame_end();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/spi_slave_xfer.md
SPI_SLAVE_XFER -- requirements
Module: spi_slave_xfer

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of flops synchronizing sclk/cs_n/mosi into clk; legal range 2..3.
REQ-002 clk  input  1  system clock (50 MHz nominal).
REQ-003 rst  input  1  reset: synchronous, active-high.
REQ-004 sclk  input  1  SPI clock from master, asynchronous, idles high.
REQ-005 cs_n  input  1  SPI chip select, asynchronous, active-low.
REQ-006 mosi  input  1  SPI data from master, asynchronous.
REQ-007 miso  output  1  SPI data to master.
REQ-008 tx_data  input  8  byte to return to master; sampled at byte start.
REQ-009 tx_taken  output  1  one-clk pulse: tx_data was captured; user may present the next byte.
REQ-010 rx_data  output  8  last complete byte received.
REQ-011 rx_valid  output  1  level: rx_data holds an unacknowledged byte.
REQ-012 rx_ack  input  1  consumer acknowledge; clears rx_valid.
REQ-013 busy  output  1  high while synchronized cs_n is low.
REQ-014 rx_overrun  output  1  sticky: byte completed while rx_valid still high.

Function
REQ-015 The block SHALL implement SPI mode 3 (CPOL=1, CPHA=1), MSB first, 8-bit frames.
REQ-016 Edge detection SHALL use the synchronized sclk/cs_n only; the supported sclk frequency is at most clk/8.
REQ-017 The state machine SHALL have states IDLE and SHIFT.
REQ-018 IDLE->SHIFT on a synchronized cs_n falling edge: tx shift register <= tx_data, bit count <= 0, tx_taken pulses for 1 clk.
REQ-019 In SHIFT, each synchronized sclk falling edge SHALL drive miso <= tx shift register MSB and shift it left, filling with 1.
REQ-020 In SHIFT, each synchronized sclk rising edge SHALL shift mosi into the rx shift register LSB and increment the bit count.
REQ-021 On the 8th rising edge: rx_data <= completed byte, rx_valid <= 1, and the tx shift register reloads from tx_data with a tx_taken pulse, in the clk cycle after the edge is detected.
REQ-022 Back-to-back bytes within one cs_n assertion SHALL be supported without gaps; the bit count wraps 8->0.
REQ-023 Latency from the 8th sclk rising pin edge to rx_valid high SHALL be at most SYNC_STAGES+2 clk.
REQ-024 rx_ack high SHALL clear rx_valid on the next clk edge; a byte completing in the same cycle as rx_ack wins (rx_valid stays 1).
REQ-025 Synchronized cs_n rising edge in any state SHALL return to IDLE, discard a partial byte (no rx_valid, no rx_data change), and drive miso <= 1.
REQ-026 cs_n deassertion SHALL take priority over a sclk edge detected in the same clk.
REQ-027 miso SHALL be 1 whenever the state is IDLE.
REQ-028 busy SHALL equal the inverse of synchronized cs_n.

Reset
REQ-029 rst SHALL force: state IDLE, miso=1, rx_data=8'h00, rx_valid=0, tx_taken=0, busy=0, rx_overrun=0, bit count 0, synchronizers to idle levels (sclk=1, cs_n=1).
REQ-030 rst during SHIFT SHALL abort the transfer; after release the block waits for a fresh cs_n falling edge.

Configuration
REQ-031 Macro SPI_SLAVE_OVERRUN_EN defined: rx_overrun sets when REQ-021 fires while rx_valid=1 and rx_ack=0, and clears only on rx_ack or rst.
REQ-032 Macro SPI_SLAVE_OVERRUN_EN undefined: rx_overrun is constant 0; rx_data is still overwritten.

Structure
REQ-033 Package spi_pkg SHALL hold the state encoding, SPI_BITS=8, and the idle levels of sclk and miso.
REQ-034 One sub-module, spi_sync (SYNC_STAGES-deep flop chain with reset value parameter), SHALL be instantiated for each of sclk, cs_n, and mosi.

Verification
REQ-035 cs_n low, tx_data=8'hA5, master sends 8'h3C at 2 MHz -> master receives 8'hA5, rx_data=8'h3C, rx_valid=1, exactly one tx_taken at start.
REQ-036 Two bytes in one cs_n, tx_data changed to 8'h0F after the first tx_taken -> master receives 8'hA5 then 8'h0F; the second tx_taken follows the 8th edge.
REQ-037 cs_n raised after 5 bits -> no rx_valid, rx_data unchanged, miso=1 within SYNC_STAGES+2 clk, state IDLE.
REQ-038 Two bytes received with no rx_ack -> rx_data = second byte; rx_overrun=1 with SPI_SLAVE_OVERRUN_EN, 0 without; rx_ack clears both.
REQ-039 rst asserted mid-byte (bit 4) -> all outputs at REQ-029 values next clk; the next full transfer of 8'h81 is received correctly.
REQ-040 rx_ack coincident with a new byte completion -> rx_valid stays 1 and rx_data holds the new byte.
